decode_stage: RTL
=================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter IW, default 16, meaning instruction word width in bits.
REQ-002 SHALL have parameter TWO_WORD_TAG, default 2'b11, meaning the value of instr_in[15:14] that marks a two-word (immediate-carrying) instruction.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port instr_in  input  16  instruction word from the fetch-stage output register.
REQ-006 SHALL have port instr_valid  input  1  instr_in carries a word this cycle.
REQ-007 SHALL have port stall  input  1  hold all decode state and outputs; ignore instr_in.
REQ-008 SHALL have port flush  input  1  discard any partial or pending instruction.
REQ-009 SHALL have port opcode  output  5  decoded instr[15:11].
REQ-010 SHALL have port rdst  output  3  decoded instr[10:8].
REQ-011 SHALL have port rsrc1  output  3  decoded instr[7:5].
REQ-012 SHALL have port rsrc2  output  3  decoded instr[4:2].
REQ-013 SHALL have port imm  output  16  immediate word; 0 for single-word instructions.
REQ-014 SHALL have port has_imm  output  1  the decoded instruction was two-word.
REQ-015 SHALL have port dec_valid  output  1  outputs hold a complete decoded instruction this cycle.
REQ-016 SHALL have port wait_imm  output  1  FSM is in S_IMM (first word held, immediate pending).

Function
REQ-017 SHALL implement a two-state FSM: S_WORD1 (expect first word) and S_IMM (expect immediate word).
REQ-018 Priority per edge SHALL be: reset, then flush, then stall, then normal operation.
REQ-019 In S_WORD1 with instr_valid=1 and instr_in[15:14]!=TWO_WORD_TAG: SHALL register opcode/rdst/rsrc1/rsrc2 from instr_in, clear imm and has_imm, set dec_valid=1 on the next cycle, and stay in S_WORD1.
REQ-020 In S_WORD1 with instr_valid=1 and instr_in[15:14]==TWO_WORD_TAG: SHALL latch the fields internally, drive dec_valid=0 next cycle, and go to S_IMM.
REQ-021 In S_IMM with instr_valid=1: SHALL load imm from instr_in, drive the held fields on the outputs, set has_imm=1, set dec_valid=1 next cycle, and return to S_WORD1; instr_in is not decoded as an opcode.
REQ-022 In S_IMM with instr_valid=0: SHALL remain in S_IMM and keep dec_valid=0.
REQ-023 Latency SHALL be one cycle from the accepting edge of the final word of an instruction to dec_valid=1.
REQ-024 Without stall, dec_valid SHALL be a single-cycle pulse per instruction and SHALL return to 0 in any cycle with no newly completed instruction.
REQ-025 While stall=1 (flush=0), FSM state and all outputs, including dec_valid, SHALL hold their values unchanged.
REQ-026 flush=1 SHALL, on the next edge, force S_WORD1, dec_valid=0, wait_imm=0, and all field outputs, imm, and has_imm to 0, even when stall=1 or in S_IMM.
REQ-027 instr_in=16'h0000 with instr_valid=1 SHALL be decoded as a normal single-word instruction (NOP, opcode 0).
REQ-028 wait_imm SHALL be a registered indication of state==S_IMM.

Reset
REQ-029 While reset=0, SHALL asynchronously force S_WORD1 and set opcode, rdst, rsrc1, rsrc2, imm, has_imm, dec_valid, and wait_imm to 0.
REQ-030 After reset deasserts, the first instr_valid word SHALL be treated as a first word.
REQ-031 Reset asserted in S_IMM SHALL discard the held first word; no dec_valid SHALL follow.

Verification
REQ-032 Single-word: instr_in=16'h2D24, valid=1 for one cycle -> next cycle dec_valid=1, opcode=5'h05, rdst=5, rsrc1=1, rsrc2=1, imm=0, has_imm=0; the following cycle dec_valid=0.
REQ-033 Two-word: 16'hC8A0 then 16'h1234 on consecutive cycles -> after the first word dec_valid=0 and wait_imm=1; after the second word dec_valid=1, opcode=5'h19, rdst=0, rsrc1=5, imm=16'h1234, has_imm=1.
REQ-034 Gap in immediate: 16'hC8A0, then 3 cycles with valid=0, then 16'hBEEF -> wait_imm=1 throughout the gap; dec_valid=1 exactly once with imm=16'hBEEF.
REQ-035 Stall hold: stall=1 for 4 cycles while dec_valid=1 -> all outputs are unchanged for 4 cycles, and words presented during the stall are ignored.
REQ-036 Flush mid-instruction: 16'hC8A0, then flush=1 with valid=1 on 16'h1234 -> dec_valid stays 0, state is S_WORD1, and the next word 16'h0000 decodes as a NOP with dec_valid=1.
REQ-037 Async reset in S_IMM: reset=0 between clock edges -> outputs go to 0 immediately; after release, 16'h2D24 decodes as in REQ-032.

Source files
------------

// File: rtl/decode_stage.sv
// Instruction decode stage: single-word instructions decode directly, and
// two-word instructions hold their first word until the immediate arrives.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   S_WORD1 | expecting the first word of an instruction
//   S_IMM   | first word held, waiting for its immediate word
module decode_stage #(
    parameter int          IW           = 16,
    parameter logic [1:0]  TWO_WORD_TAG = 2'b11
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [IW-1:0] instr_in,
    input  logic          instr_valid,
    input  logic          stall,
    input  logic          flush,
    output logic [4:0]    opcode,
    output logic [2:0]    rdst,
    output logic [2:0]    rsrc1,
    output logic [2:0]    rsrc2,
    output logic [IW-1:0] imm,
    output logic          has_imm,
    output logic          dec_valid,
    output logic          wait_imm
);

    typedef enum logic {
        S_WORD1 = 1'b0,
        S_IMM   = 1'b1
    } state_t;

    state_t     state;
    logic [4:0] opcode_held;
    logic [2:0] rdst_held;
    logic [2:0] rsrc1_held;
    logic [2:0] rsrc2_held;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_WORD1;
            opcode_held <= '0;
            rdst_held   <= '0;
            rsrc1_held  <= '0;
            rsrc2_held  <= '0;
            opcode      <= '0;
            rdst        <= '0;
            rsrc1       <= '0;
            rsrc2       <= '0;
            imm         <= '0;
            has_imm     <= 1'b0;
            dec_valid   <= 1'b0;
            wait_imm    <= 1'b0;
        end else if (flush) begin
            state       <= S_WORD1;
            opcode_held <= '0;
            rdst_held   <= '0;
            rsrc1_held  <= '0;
            rsrc2_held  <= '0;
            opcode      <= '0;
            rdst        <= '0;
            rsrc1       <= '0;
            rsrc2       <= '0;
            imm         <= '0;
            has_imm     <= 1'b0;
            dec_valid   <= 1'b0;
            wait_imm    <= 1'b0;
        end else if (!stall) begin
            dec_valid <= 1'b0;
            case (state)
                S_WORD1: begin
                    if (instr_valid) begin
                        if (instr_in[15:14] == TWO_WORD_TAG) begin
                            // Outputs keep their last value; dec_valid low marks them stale.
                            opcode_held <= instr_in[15:11];
                            rdst_held   <= instr_in[10:8];
                            rsrc1_held  <= instr_in[7:5];
                            rsrc2_held  <= instr_in[4:2];
                            state       <= S_IMM;
                            wait_imm    <= 1'b1;
                        end else begin
                            opcode    <= instr_in[15:11];
                            rdst      <= instr_in[10:8];
                            rsrc1     <= instr_in[7:5];
                            rsrc2     <= instr_in[4:2];
                            imm       <= '0;
                            has_imm   <= 1'b0;
                            dec_valid <= 1'b1;
                        end
                    end
                end
                S_IMM: begin
                    if (instr_valid) begin
                        opcode    <= opcode_held;
                        rdst      <= rdst_held;
                        rsrc1     <= rsrc1_held;
                        rsrc2     <= rsrc2_held;
                        imm       <= instr_in;
                        has_imm   <= 1'b1;
                        dec_valid <= 1'b1;
                        state     <= S_WORD1;
                        wait_imm  <= 1'b0;
                    end
                end
                default: begin
                    state    <= S_WORD1;
                    wait_imm <= 1'b0;
                end
            endcase
        end
    end

endmodule
